alu6_op_sequencer: RTL and testbench

//   Operand/result sequencer wrapped around the 6-bit add/sub datapath (a, b, carryIn, select -> result, equal).

---
 rtl/alu6_op_sequencer_if.sv | 46 ++++
 rtl/alu6_op_sequencer.sv | 117 +++++++++++
 tb/tb_alu6_op_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu6_op_sequencer_if.sv
// Handshake and adder-side bundle for alu6_op_sequencer.
// SEQ_OVF_EN adds the captured overflow flag out_ovf.
interface alu6_op_sequencer_if #(
    parameter int WIDTH = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_en;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryIn;
    logic             select;
    logic [WIDTH-1:0] result;
    logic             equal;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_equal;
    logic [7:0]       done_cnt;
`ifdef SEQ_OVF_EN
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_en, result, equal, out_ready,
        input  in_ready, a, b, carryIn, select, out_valid, out_result, out_equal, done_cnt, out_ovf
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_en, result, equal, out_ready,
        output in_ready, a, b, carryIn, select, out_valid, out_result, out_equal, done_cnt, out_ovf
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_sub, in_en, result, equal, out_ready,
        input  in_ready, a, b, carryIn, select, out_valid, out_result, out_equal, done_cnt
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_en, result, equal, out_ready,
        output in_ready, a, b, carryIn, select, out_valid, out_result, out_equal, done_cnt
    );
`endif
endinterface

// File: rtl/alu6_op_sequencer.sv
// Operand/result sequencer around the 6-bit add/sub datapath: drive, settle, capture, hand off.
// Optional macro SEQ_OVF_EN adds a captured signed-overflow flag (bus.out_ovf).
//
// state  | meaning
// IDLE   | ready for a new operation; adder inputs keep the last operands
// SETTLE | operands on adder, counting down the settle time
// HOLD   | result captured and presented until out_ready
module alu6_op_sequencer #(
    parameter int WIDTH  = 6,
    parameter int SETTLE = 1    // 1..15
) (
    input logic                 i_clk,
    input logic                 i_reset,
    alu6_op_sequencer_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry_in;
    logic             r_select;
    logic [WIDTH-1:0] r_out_result;
    logic             r_out_equal;
    logic             r_out_valid;
    logic [7:0]       r_done_cnt;

    logic             w_in_ready;
    logic             w_accept;

    assign w_in_ready = (r_state == ST_IDLE) && !i_reset;
    assign w_accept   = bus.in_valid && w_in_ready;

`ifdef SEQ_OVF_EN
    logic r_out_ovf;
    logic w_ovf;

    // Sign-based overflow of the operation currently on the adder inputs.
    always_comb begin
        w_ovf = 1'b0;
        if (r_select) begin
            if (r_carry_in)
                w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (bus.result[WIDTH-1] != r_a[WIDTH-1]);
            else
                w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (bus.result[WIDTH-1] != r_a[WIDTH-1]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_out_ovf <= 1'b0;
        else if (r_state == ST_SETTLE && r_cnt == 4'd1)
            r_out_ovf <= w_ovf;
    end

    assign bus.out_ovf = r_out_ovf;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_carry_in   <= 1'b0;
            r_select     <= 1'b0;
            r_out_result <= '0;
            r_out_equal  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_done_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a        <= bus.in_a;
                        r_b        <= bus.in_b;
                        r_carry_in <= bus.in_sub;
                        r_select   <= bus.in_en;
                        r_cnt      <= SETTLE_CNT;
                        r_state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_out_result <= bus.result;
                        r_out_equal  <= bus.equal;
                        r_out_valid  <= 1'b1;
                        r_state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_done_cnt  <= r_done_cnt + 8'd1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.a          = r_a;
    assign bus.b          = r_b;
    assign bus.carryIn    = r_carry_in;
    assign bus.select     = r_select;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_equal  = r_out_equal;
    assign bus.done_cnt   = r_done_cnt;
endmodule

// File: tb/tb_alu6_op_sequencer.sv
// Self-checking bench for alu6_op_sequencer (SETTLE=3) with a behavioural 6-bit add/sub adder.
module tb_alu6_op_sequencer;
    localparam int WIDTH  = 6;
    localparam int SETTLE = 3;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [7:0] exp_done;

    alu6_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu6_op_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: select=0 zeroes the result; equal always compares operands.
    logic [WIDTH-1:0] m_sum;
    logic [WIDTH-1:0] m_diff;
    always_comb begin
        m_sum      = bus.a + bus.b;
        m_diff     = bus.a - bus.b;
        bus.result = bus.select ? (bus.carryIn ? m_diff : m_sum) : '0;
        bus.equal  = (bus.a == bus.b);
    end

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic       sub;
        logic       en;
        logic [5:0] exp_res;
        logic       exp_eq;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic accept_op(input logic [5:0] a, input logic [5:0] b, input logic sub, input logic en);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_en    = en;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("busy_after_accept", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic wait_valid();
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(SETTLE));
    endtask

    task automatic release_op();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        exp_done = exp_done + 8'd1;
        check("done_cnt", 32'(bus.done_cnt), 32'(exp_done));
        check("valid_cleared", 32'(bus.out_valid), 32'd0);
        check("back_to_idle", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        exp_done = 8'd0;
        //           a    b   sub en  res  eq ovf
        vecs[0]  = '{6'd12, 6'd51, 1'b0, 1'b1, 6'd63, 1'b0, 1'b0};
        vecs[1]  = '{6'd42, 6'd21, 1'b1, 1'b1, 6'd21, 1'b0, 1'b1};
        vecs[2]  = '{6'd48, 6'd48, 1'b1, 1'b1, 6'd0,  1'b1, 1'b0};
        vecs[3]  = '{6'd63, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, 1'b0};
        vecs[4]  = '{6'd5,  6'd5,  1'b0, 1'b0, 6'd0,  1'b1, 1'b0};
        vecs[5]  = '{6'd20, 6'd20, 1'b0, 1'b1, 6'd40, 1'b1, 1'b1};
        vecs[6]  = '{6'd3,  6'd5,  1'b1, 1'b1, 6'd62, 1'b0, 1'b0};
        vecs[7]  = '{6'd63, 6'd1,  1'b0, 1'b1, 6'd0,  1'b0, 1'b0};
        vecs[8]  = '{6'd31, 6'd1,  1'b0, 1'b1, 6'd32, 1'b0, 1'b1};
        vecs[9]  = '{6'd32, 6'd1,  1'b1, 1'b1, 6'd31, 1'b0, 1'b1};
        vecs[10] = '{6'd3,  6'd1,  1'b1, 1'b1, 6'd2,  1'b0, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.in_en     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", 32'(bus.out_result), 32'd0);
        check("rst_done_cnt", 32'(bus.done_cnt), 32'd0);
        check("rst_a", 32'(bus.a), 32'd0);
`ifdef SEQ_OVF_EN
        check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-SETTLE aborts the operation without counting it.
        accept_op(6'd10, 6'd20, 1'b0, 1'b1);
        check("midsettle_a_driven", 32'(bus.a), 32'd10);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_a", 32'(bus.a), 32'd0);
        check("abort_b", 32'(bus.b), 32'd0);
        check("abort_select", 32'(bus.select), 32'd0);
        check("abort_out_result", 32'(bus.out_result), 32'd0);
        check("abort_done_cnt", 32'(bus.done_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (SETTLE + 2) @(posedge clk);
        #1;
        check("abort_no_late_valid", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < 11; i++) begin
            accept_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].en);
            check("adder_a", 32'(bus.a), 32'(vecs[i].a));
            check("adder_carryIn", 32'(bus.carryIn), 32'(vecs[i].sub));
            wait_valid();
            check("out_result", 32'(bus.out_result), 32'(vecs[i].exp_res));
            check("out_equal", 32'(bus.out_equal), 32'(vecs[i].exp_eq));
`ifdef SEQ_OVF_EN
            check("out_ovf", 32'(bus.out_ovf), 32'(vecs[i].exp_ovf));
`endif
            release_op();
            check("idle_keeps_b", 32'(bus.b), 32'(vecs[i].b));
        end

        // Backpressure: result held, new requests ignored.
        accept_op(6'd7, 6'd9, 1'b0, 1'b1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_a     = 6'(i + 30);
            bus.in_b     = 6'(i);
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_result", 32'(bus.out_result), 32'd16);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_a_stable", 32'(bus.a), 32'd7);
        end
        bus.in_valid = 1'b0;
        release_op();
        check("bp_a_after", 32'(bus.a), 32'd7);

        // Run operations until done_cnt wraps.
        begin
            int guard;
            guard = 0;
            while (exp_done != 8'd0 && guard < 300) begin
                accept_op(6'(guard), 6'(guard + 1), guard[0], 1'b1);
                wait_valid();
                release_op();
                guard++;
            end
        end
        check("wrap_done_cnt", 32'(bus.done_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
